// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single shared memory with fixed read latency.
// One transaction in flight at a time; ties alternate, with D winning the first tie after reset.
module mem_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_type,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [2:0]  m_type,
  input  logic [31:0] m_rdata
);

  // IDLE: arbitrate | ISSUE: memory strobe | WAIT: count MEM_LAT | RESP: rvalid pulse
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic {G_I, G_D} port_t;

  localparam logic [3:0] LAT_CNT = 4'(MEM_LAT);

  state_t      r_state;
  port_t       r_last_gnt;
  logic [3:0]  r_cnt;
  logic        r_store;
  logic        r_m_req;
  logic        r_m_we;
  logic [31:0] r_m_addr;
  logic [31:0] r_m_wdata;
  logic [2:0]  r_m_type;
  logic        r_i_rvalid;
  logic        r_d_rvalid;
  logic [31:0] r_i_rdata;
  logic [31:0] r_d_rdata;

  logic w_idle;
  logic w_i_win;
  logic w_d_win;

  // Grants are combinational so the requester sees acceptance in its request cycle.
  assign w_idle  = (r_state == S_IDLE) && !reset;
  assign w_i_win = w_idle && i_req && (!d_req || (r_last_gnt == G_D));
  assign w_d_win = w_idle && d_req && (!i_req || (r_last_gnt == G_I));

  assign i_gnt    = w_i_win;
  assign d_gnt    = w_d_win;
  assign i_rvalid = r_i_rvalid;
  assign i_rdata  = r_i_rdata;
  assign d_rvalid = r_d_rvalid;
  assign d_rdata  = r_d_rdata;
  assign m_req    = r_m_req;
  assign m_we     = r_m_we;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;
  assign m_type   = r_m_type;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_last_gnt <= G_I;
      r_cnt      <= 4'd0;
      r_store    <= 1'b0;
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= 32'd0;
      r_m_wdata  <= 32'd0;
      r_m_type   <= 3'd0;
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_rdata  <= 32'd0;
      r_d_rdata  <= 32'd0;
    end else begin
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_d_win) begin
            r_state    <= S_ISSUE;
            r_last_gnt <= G_D;
            r_store    <= d_we;
            r_m_req    <= 1'b1;
            r_m_we     <= d_we;
            r_m_addr   <= d_addr;
            r_m_wdata  <= d_wdata;
            r_m_type   <= d_type;
          end else if (w_i_win) begin
            r_state    <= S_ISSUE;
            r_last_gnt <= G_I;
            r_store    <= 1'b0;
            r_m_req    <= 1'b1;
            r_m_we     <= 1'b0;
            r_m_addr   <= i_addr;
            r_m_type   <= 3'b010;
          end
        end
        S_ISSUE: begin
          r_cnt   <= LAT_CNT;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Terminal count: this edge is MEM_LAT cycles after ISSUE, so memory data is valid now.
          if (r_cnt == 4'd1) begin
            r_cnt   <= 4'd0;
            r_state <= S_RESP;
            if (r_last_gnt == G_I) begin
              r_i_rvalid <= 1'b1;
              r_i_rdata  <= m_rdata;
            end else begin
              r_d_rvalid <= 1'b1;
              if (!r_store) r_d_rdata <= m_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, reset/contention/latency sequences, and a
// randomized run against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [2:0]  d_type;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [2:0]  m_type;

  logic        b_i_req, b_i_gnt, b_i_rvalid;
  logic [31:0] b_i_addr, b_i_rdata;
  logic        b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
  logic [31:0] b_d_addr, b_d_wdata, b_d_rdata;
  logic [2:0]  b_d_type;
  logic        b_m_req, b_m_we;
  logic [31:0] b_m_addr, b_m_wdata, b_m_rdata;
  logic [2:0]  b_m_type;

  mem_arbiter #(.MEM_LAT(LAT)) u_dut1 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_type(d_type),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_type(m_type),
    .m_rdata(m_rdata)
  );

  mem_arbiter #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_type(b_d_type),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .m_req(b_m_req), .m_we(b_m_we), .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_type(b_m_type),
    .m_rdata(b_m_rdata)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr, dw;
    logic [31:0] da, dwd;
    logic [2:0]  dt;
    logic [31:0] mr;
    logic        e_ig, e_dg, e_mreq, e_mwe;
    logic [31:0] e_maddr, e_mwdata;
    logic [2:0]  e_mtype;
    logic        e_irv;
    logic [31:0] e_ird;
    logic        e_drv;
    logic [31:0] e_drd;
  } vec_t;

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia,
    input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dwd,
    input logic [2:0] dt, input logic [31:0] mr,
    input logic eig, input logic edg, input logic emr, input logic emw,
    input logic [31:0] ema, input logic [31:0] emwd, input logic [2:0] emt,
    input logic eirv, input logic [31:0] eird, input logic edrv, input logic [31:0] edrd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd; v.dt = dt; v.mr = mr;
    v.e_ig = eig; v.e_dg = edg; v.e_mreq = emr; v.e_mwe = emw;
    v.e_maddr = ema; v.e_mwdata = emwd; v.e_mtype = emt;
    v.e_irv = eirv; v.e_ird = eird; v.e_drv = edrv; v.e_drd = edrd;
    return v;
  endfunction

  task automatic drv(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                     input logic [31:0] da, input logic [31:0] dwd, input logic [2:0] dt,
                     input logic [31:0] mr);
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd; d_type = dt;
    m_rdata = mr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    b_i_req = 0; b_i_addr = 0; b_d_req = 0; b_d_we = 0; b_d_addr = 0; b_d_wdata = 0;
    b_d_type = 0; b_m_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  vec_t tbl[16];

  // Transaction-level model state for the randomized run.
  int          free_at, t_cyc;
  bit          last_d, t_d, t_we, ip, dp, idle, eg_i, eg_d;
  logic [31:0] t_addr, t_wdata, ia_r, da_r, dwd_r, cap, mr_r;
  logic [2:0]  t_type, dt_r;
  bit          dw_r;
  logic [31:0] e_maddr, e_mwdata, e_ird, e_drd;
  logic [2:0]  e_mtype;

  initial begin
    reset = 1'b1;
    tbl[0]  = mk(1, 32'h10, 0, 0, 0, 0, 0, 0,
                 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 1, 0, 32'h10, 0, 3'd2, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h00500093,
                 0, 0, 0, 0, 32'h10, 0, 3'd2, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 32'h10, 0, 3'd2, 1, 32'h00500093, 0, 0);
    tbl[4]  = mk(0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 3'd2, 0,
                 0, 1, 0, 0, 32'h10, 0, 3'd2, 0, 32'h00500093, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 3'd2, 0, 32'h00500093, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF,
                 0, 0, 0, 0, 32'h100, 32'hDEADBEEF, 3'd2, 0, 32'h00500093, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 32'h100, 32'hDEADBEEF, 3'd2, 0, 32'h00500093, 1, 0);
    tbl[8]  = mk(0, 0, 1, 0, 32'h200, 32'h5A5A5A5A, 3'd4, 0,
                 0, 1, 0, 0, 32'h100, 32'hDEADBEEF, 3'd2, 0, 32'h00500093, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 1, 0, 32'h200, 32'h5A5A5A5A, 3'd4, 0, 32'h00500093, 0, 0);
    tbl[10] = mk(1, 32'h44, 0, 0, 0, 0, 0, 32'hCAFEF00D,
                 0, 0, 0, 0, 32'h200, 32'h5A5A5A5A, 3'd4, 0, 32'h00500093, 0, 0);
    tbl[11] = mk(1, 32'h44, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 32'h200, 32'h5A5A5A5A, 3'd4, 0, 32'h00500093, 1, 32'hCAFEF00D);
    tbl[12] = mk(1, 32'h44, 0, 0, 0, 0, 0, 0,
                 1, 0, 0, 0, 32'h200, 32'h5A5A5A5A, 3'd4, 0, 32'h00500093, 0, 32'hCAFEF00D);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 1, 0, 32'h44, 32'h5A5A5A5A, 3'd2, 0, 32'h00500093, 0, 32'hCAFEF00D);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 32'h11112222,
                 0, 0, 0, 0, 32'h44, 32'h5A5A5A5A, 3'd2, 0, 32'h00500093, 0, 32'hCAFEF00D);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 32'h44, 32'h5A5A5A5A, 3'd2, 1, 32'h11112222, 0, 32'hCAFEF00D);

    // Reset state
    do_reset();
    reset = 1'b1;
    #1;
    chk("rst.m_addr", m_addr, 0);
    chk("rst.i_rdata", i_rdata, 0);
    chk("rst.m_req", m_req, 0);
    reset = 1'b0;

    // Directed vector table: fetch, store, load, late fetch request
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drv(tbl[k].ir, tbl[k].ia, tbl[k].dr, tbl[k].dw, tbl[k].da, tbl[k].dwd, tbl[k].dt, tbl[k].mr);
      #2;
      chk($sformatf("vec%0d.i_gnt", k), i_gnt, tbl[k].e_ig);
      chk($sformatf("vec%0d.d_gnt", k), d_gnt, tbl[k].e_dg);
      chk($sformatf("vec%0d.m_req", k), m_req, tbl[k].e_mreq);
      chk($sformatf("vec%0d.m_we", k), m_we, tbl[k].e_mwe);
      chk($sformatf("vec%0d.m_addr", k), m_addr, tbl[k].e_maddr);
      chk($sformatf("vec%0d.m_wdata", k), m_wdata, tbl[k].e_mwdata);
      chk($sformatf("vec%0d.m_type", k), m_type, tbl[k].e_mtype);
      chk($sformatf("vec%0d.i_rvalid", k), i_rvalid, tbl[k].e_irv);
      chk($sformatf("vec%0d.i_rdata", k), i_rdata, tbl[k].e_ird);
      chk($sformatf("vec%0d.d_rvalid", k), d_rvalid, tbl[k].e_drv);
      chk($sformatf("vec%0d.d_rdata", k), d_rdata, tbl[k].e_drd);
      step();
    end

    // Contention: both requests held high, grants alternate D, I, D, I every 4 cycles
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drv(1, 32'h1000 + k, 1, 0, 32'h2000 + k, 0, 3'd2, 32'h0);
      #2;
      chk($sformatf("cont%0d.d_gnt", k), d_gnt, (k % 4 == 0) && ((k / 4) % 2 == 0));
      chk($sformatf("cont%0d.i_gnt", k), i_gnt, (k % 4 == 0) && ((k / 4) % 2 == 1));
      step();
    end

    // Reset during RESP: outputs clear at once, first tie afterwards goes to D
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drv(k == 0, 32'h20, 0, 0, 0, 0, 0, (k == 2) ? 32'hABCD : 32'h0);
      #2;
      if (k == 3) chk("rresp.i_rvalid_before", i_rvalid, 1);
      if (k < 3) step();
    end
    #1;
    reset = 1'b1;
    drv(1, 32'h30, 1, 0, 32'h40, 0, 3'd2, 0);
    #1;
    chk("rresp.i_rvalid", i_rvalid, 0);
    chk("rresp.i_rdata", i_rdata, 0);
    chk("rresp.m_addr", m_addr, 0);
    chk("rresp.m_type", m_type, 0);
    chk("rresp.i_gnt", i_gnt, 0);
    chk("rresp.d_gnt", d_gnt, 0);
    step();
    reset = 1'b0;
    #2;
    chk("rresp.post_d_gnt", d_gnt, 1);
    chk("rresp.post_i_gnt", i_gnt, 0);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rresp.post_m_req", m_req, 1);
    chk("rresp.post_m_addr", m_addr, 32'h40);
    repeat (3) step();

    // Reset during ISSUE: m_req drops immediately, aborted load never responds
    do_reset();
    drv(0, 0, 1, 0, 32'h300, 0, 3'd2, 0);
    #2;
    chk("riss.d_gnt", d_gnt, 1);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 32'h77777777);
    #2;
    chk("riss.m_req_before", m_req, 1);
    reset = 1'b1;
    #1;
    chk("riss.m_req", m_req, 0);
    step();
    step();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #2;
      chk($sformatf("riss%0d.d_rvalid", k), d_rvalid, 0);
      chk($sformatf("riss%0d.d_rdata", k), d_rdata, 0);
      step();
    end

    // MEM_LAT=3 instance: load latency and grant blackout
    do_reset();
    for (int k = 0; k < 7; k++) begin
      b_i_req = 1'b1; b_i_addr = 32'h80;
      b_d_req = (k == 0); b_d_we = 1'b0; b_d_addr = 32'h300; b_d_wdata = 0; b_d_type = 3'd2;
      b_m_rdata = (k == 4) ? 32'h12345678 : (32'hBAD00000 + k);
      #2;
      chk($sformatf("lat3_%0d.d_gnt", k), b_d_gnt, k == 0);
      chk($sformatf("lat3_%0d.i_gnt", k), b_i_gnt, k == 6);
      chk($sformatf("lat3_%0d.m_req", k), b_m_req, k == 1);
      chk($sformatf("lat3_%0d.d_rvalid", k), b_d_rvalid, k == 5);
      chk($sformatf("lat3_%0d.i_rvalid", k), b_i_rvalid, 0);
      if (k == 1) chk("lat3.m_addr", b_m_addr, 32'h300);
      if (k == 1) chk("lat3.m_we", b_m_we, 0);
      if (k >= 5) chk($sformatf("lat3_%0d.d_rdata", k), b_d_rdata, 32'h12345678);
      step();
    end
    chk("lat3.i_rdata", b_i_rdata, 0);
    chk("lat3.m_wdata", b_m_wdata, 0);
    chk("lat3.m_type", b_m_type, 3'd2);

    // Randomized run against transaction-level model
    do_reset();
    free_at = 0; t_cyc = -100; last_d = 0; t_d = 0; t_we = 0; ip = 0; dp = 0;
    t_addr = 0; t_wdata = 0; t_type = 0; cap = 0;
    ia_r = 0; da_r = 0; dwd_r = 0; dt_r = 0; dw_r = 0;
    e_maddr = 0; e_mwdata = 0; e_mtype = 0; e_ird = 0; e_drd = 0;
    for (int n = 0; n < 500; n++) begin
      if (!ip && $urandom_range(0, 2) != 0) begin
        ip = 1; ia_r = $urandom;
      end
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = 1; da_r = $urandom; dw_r = 1'($urandom_range(0, 1)); dwd_r = $urandom;
        dt_r = 3'($urandom_range(0, 7));
      end
      mr_r = $urandom;
      drv(ip, ip ? ia_r : $urandom, dp, dp ? dw_r : 1'($urandom_range(0, 1)),
          dp ? da_r : $urandom, dp ? dwd_r : $urandom, dp ? dt_r : 3'($urandom_range(0, 7)), mr_r);
      #2;
      idle = (n >= free_at);
      eg_d = idle && dp && (!ip || !last_d);
      eg_i = idle && ip && (!dp || last_d);
      if (n == t_cyc + LAT + 2) begin
        if (!t_d) e_ird = cap;
        else if (!t_we) e_drd = cap;
      end
      chk($sformatf("rnd%0d.i_gnt", n), i_gnt, eg_i);
      chk($sformatf("rnd%0d.d_gnt", n), d_gnt, eg_d);
      chk($sformatf("rnd%0d.m_req", n), m_req, n == t_cyc + 1);
      chk($sformatf("rnd%0d.m_we", n), m_we, (n == t_cyc + 1) && t_we);
      chk($sformatf("rnd%0d.m_addr", n), m_addr, e_maddr);
      chk($sformatf("rnd%0d.m_wdata", n), m_wdata, e_mwdata);
      chk($sformatf("rnd%0d.m_type", n), m_type, e_mtype);
      chk($sformatf("rnd%0d.i_rvalid", n), i_rvalid, (n == t_cyc + LAT + 2) && !t_d);
      chk($sformatf("rnd%0d.d_rvalid", n), d_rvalid, (n == t_cyc + LAT + 2) && t_d);
      chk($sformatf("rnd%0d.i_rdata", n), i_rdata, e_ird);
      chk($sformatf("rnd%0d.d_rdata", n), d_rdata, e_drd);
      if (n == t_cyc + LAT + 1) cap = mr_r;
      if (eg_d || eg_i) begin
        t_cyc = n; t_d = eg_d; last_d = eg_d; free_at = n + LAT + 3;
        if (eg_d) begin
          t_we = dw_r; e_maddr = da_r; e_mwdata = dwd_r; e_mtype = dt_r; dp = 0;
        end else begin
          t_we = 0; e_maddr = ia_r; e_mtype = 3'b010; ip = 0;
        end
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
